defuzz_scheduler: RTL and testbench

DEFUZZ_SCHEDULER -- requirements
Module: defuzz_scheduler

---
 rtl/defuzz_scheduler_pkg.sv | 23 ++
 rtl/defuzz_scheduler_rule_table_regs.sv | 32 +++
 rtl/defuzz_scheduler.sv | 169 ++++++++++++++++
 tb/tb_defuzz_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defuzz_scheduler_pkg.sv
// Shared fuzzy-engine definitions: scheduler state encoding, table geometry, Q12 constants
// and the rule-table entry layout.
package defuzz_scheduler_pkg;

    localparam int unsigned MAX_RULES = 8;
    localparam logic [31:0] Q12_ONE   = 32'h0000_1000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CWRST = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [95:0] mf;
        logic [31:0] degree;
    } rule_entry_t;

    function automatic logic [47:0] sext48(input logic [31:0] v);
        return {{16{v[31]}}, v};
    endfunction

endpackage

// File: rtl/defuzz_scheduler_rule_table_regs.sv
// Rule table register file: one synchronous write port, one asynchronous read port,
// cleared to zero on reset.
module rule_table_regs
    import defuzz_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_RULES,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_idx,
    input  rule_entry_t   i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    output rule_entry_t   o_rd_data
);

    rule_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/defuzz_scheduler.sv
// Defuzzification batch scheduler: scans the rule table, issues firing rules to the
// weight-calculation datapath and accumulates the returned per-rule area/weighted sums.
module defuzz_scheduler #(
    parameter int unsigned MAX_RULES     = 8,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned CW_RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_idx,
    input  logic [95:0] cfg_mf,
    input  logic [31:0] cfg_degree,
    input  logic        start,
    input  logic [3:0]  rule_count,
    output logic        busy,
    output logic        cw_rst,
    output logic        cw_input_valid,
    output logic [31:0] cw_consequent_degree,
    output logic [95:0] cw_outMF_data,
    input  logic        cw_output_valid,
    input  logic [31:0] cw_area_sum,
    input  logic [31:0] cw_weighted_sum,
    output logic        result_valid,
    output logic [47:0] total_area,
    output logic [47:0] total_weighted,
    output logic [3:0]  rules_used,
    output logic        timeout_err
);
    import defuzz_scheduler_pkg::*;

    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned CWW = $clog2(CW_RST_CYCLES + 1);

    logic [2:0]     r_state;
    logic [2:0]     w_state_d;
    logic [3:0]     r_count;
    logic [3:0]     r_idx;
    logic [3:0]     r_issued;
    logic [3:0]     r_ret;
    logic [TW-1:0]  r_to_cnt;
    logic [CWW-1:0] r_cw_cnt;
    logic           r_cw_rst;
    logic           r_cw_valid;
    logic [31:0]    r_cw_deg;
    logic [95:0]    r_cw_mf;
    logic [47:0]    r_acc_area;
    logic [47:0]    r_acc_wsum;
    logic           r_timeout_err;

    rule_entry_t    w_entry;
    rule_entry_t    w_wr_entry;
    logic           w_we;
    logic           w_accept;
    logic           w_fire;
    logic           w_last;
    logic           w_ret_strobe;
    logic           w_all_back;
    logic           w_cw_done;
    logic           w_to_hit;
    logic [3:0]     w_issued_d;
    logic [3:0]     w_ret_d;

    assign w_we       = cfg_we && (r_state == ST_IDLE);
    assign w_wr_entry = '{mf: cfg_mf, degree: cfg_degree};

    rule_table_regs u_rule_table (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_we      (w_we),
        .i_wr_idx  (cfg_idx),
        .i_wr_data (w_wr_entry),
        .i_rd_idx  (r_idx[2:0]),
        .o_rd_data (w_entry)
    );

    assign w_accept     = (r_state == ST_IDLE) && start && ({28'd0, rule_count} <= MAX_RULES);
    // Only strictly positive firing strengths are worth sending to the datapath.
    assign w_fire       = (r_state == ST_ISSUE) && !w_entry.degree[31] &&
                          (w_entry.degree != 32'd0);
    assign w_last       = (r_idx == (r_count - 4'd1));
    assign w_ret_strobe = cw_output_valid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_issued_d   = r_issued + {3'd0, w_fire};
    assign w_ret_d      = r_ret + {3'd0, w_ret_strobe};
    assign w_all_back   = (w_ret_d == r_issued);
    assign w_cw_done    = (r_cw_cnt == CWW'(CW_RST_CYCLES - 1));
    assign w_to_hit     = (r_to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_d = ST_CWRST;
            ST_CWRST: if (w_cw_done) w_state_d = (r_count == 4'd0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (w_last) w_state_d = (w_issued_d == 4'd0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (w_all_back || w_to_hit) w_state_d = ST_DONE;
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_idx         <= '0;
            r_issued      <= '0;
            r_ret         <= '0;
            r_to_cnt      <= '0;
            r_cw_cnt      <= '0;
            r_cw_rst      <= 1'b0;
            r_cw_valid    <= 1'b0;
            r_cw_deg      <= '0;
            r_cw_mf       <= '0;
            r_acc_area    <= '0;
            r_acc_wsum    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cw_rst   <= (w_state_d != ST_CWRST);
            r_cw_valid <= w_fire;
            if (w_fire) begin
                r_cw_deg <= w_entry.degree;
                r_cw_mf  <= w_entry.mf;
            end
            if (w_accept) begin
                r_count       <= rule_count;
                r_idx         <= '0;
                r_issued      <= '0;
                r_ret         <= '0;
                r_to_cnt      <= '0;
                r_cw_cnt      <= '0;
                r_acc_area    <= '0;
                r_acc_wsum    <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                if (r_state == ST_CWRST) begin
                    r_cw_cnt <= r_cw_cnt + CWW'(1);
                end
                if (r_state == ST_ISSUE) begin
                    r_idx    <= r_idx + 4'd1;
                    r_issued <= w_issued_d;
                end
                if (w_ret_strobe) begin
                    r_ret      <= w_ret_d;
                    r_acc_area <= r_acc_area + sext48(cw_area_sum);
                    r_acc_wsum <= r_acc_wsum + sext48(cw_weighted_sum);
                end
                if (r_state == ST_DRAIN) begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                    if (!w_all_back && w_to_hit) begin
                        r_timeout_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy                 = (r_state != ST_IDLE);
    assign result_valid         = (r_state == ST_DONE);
    assign cw_rst               = r_cw_rst;
    assign cw_input_valid       = r_cw_valid;
    assign cw_consequent_degree = r_cw_deg;
    assign cw_outMF_data        = r_cw_mf;
    assign total_area           = r_acc_area;
    assign total_weighted       = r_acc_wsum;
    assign rules_used           = r_issued;
    assign timeout_err          = r_timeout_err;

endmodule

// File: tb/tb_defuzz_scheduler.sv
// Directed bench for defuzz_scheduler: vector table of complete batches plus hand-written
// sequences for busy-time writes/starts, oversize starts and reset during drain.
module tb_defuzz_scheduler;
    import defuzz_scheduler_pkg::*;

    localparam logic [255:0] ALLPOS = {32'h1007, 32'h1006, 32'h1005, 32'h1004,
                                       32'h1003, 32'h1002, 32'h1001, 32'h1000};

    typedef struct packed {
        logic [3:0]   n;
        logic [255:0] degs;
        logic [31:0]  area;
        logic [31:0]  wsum;
        logic [31:0]  drop_deg;
        logic [3:0]   exp_used;
        logic [47:0]  exp_area;
        logic [47:0]  exp_wsum;
        logic         exp_to;
        logic [31:0]  exp_last_deg;
        logic [2:0]   exp_last_idx;
        int           exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [95:0] cfg_mf;
    logic [31:0] cfg_degree;
    logic        start;
    logic [3:0]  rule_count;
    logic        busy;
    logic        cw_rst;
    logic        cw_input_valid;
    logic [31:0] cw_consequent_degree;
    logic [95:0] cw_outMF_data;
    logic        cw_output_valid;
    logic [31:0] cw_area_sum;
    logic [31:0] cw_weighted_sum;
    logic        result_valid;
    logic [47:0] total_area;
    logic [47:0] total_weighted;
    logic [3:0]  rules_used;
    logic        timeout_err;

    int n_applied = 0;
    int n_miscompares = 0;

    logic [31:0] m_area;
    logic [31:0] m_wsum;
    logic [31:0] m_drop_deg;
    logic [2:0]  p_v;
    logic [31:0] p_a [3];
    logic [31:0] p_w [3];

    always #5 clk = ~clk;

    defuzz_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_we               (cfg_we),
        .cfg_idx              (cfg_idx),
        .cfg_mf               (cfg_mf),
        .cfg_degree           (cfg_degree),
        .start                (start),
        .rule_count           (rule_count),
        .busy                 (busy),
        .cw_rst               (cw_rst),
        .cw_input_valid       (cw_input_valid),
        .cw_consequent_degree (cw_consequent_degree),
        .cw_outMF_data        (cw_outMF_data),
        .cw_output_valid      (cw_output_valid),
        .cw_area_sum          (cw_area_sum),
        .cw_weighted_sum      (cw_weighted_sum),
        .result_valid         (result_valid),
        .total_area           (total_area),
        .total_weighted       (total_weighted),
        .rules_used           (rules_used),
        .timeout_err          (timeout_err)
    );

    // Datapath stand-in: fixed 3-cycle latency, optionally swallowing one issued degree.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_v <= '0;
        end else begin
            p_v    <= {p_v[1:0], cw_input_valid && (cw_consequent_degree != m_drop_deg)};
            p_a[0] <= m_area;
            p_a[1] <= p_a[0];
            p_a[2] <= p_a[1];
            p_w[0] <= m_wsum;
            p_w[1] <= p_w[0];
            p_w[2] <= p_w[1];
        end
    end

    assign cw_output_valid = p_v[2];
    assign cw_area_sum     = p_a[2];
    assign cw_weighted_sum = p_w[2];

    function automatic logic [95:0] mf_of(input int i);
        return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_table(input logic [255:0] degs);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we     = 1'b1;
            cfg_idx    = 3'(i);
            cfg_degree = degs[32*i +: 32];
            cfg_mf     = mf_of(i);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_batch(input logic [3:0] n, output int lat);
        @(negedge clk);
        start      = 1'b1;
        rule_count = n;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!result_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!result_valid) begin
            n_applied++;
            n_miscompares++;
            $display("FAIL batch_wait: no result_valid after %0d cycles, expected one", lat);
        end
    endtask

    initial begin
        vec_t vecs [7];
        int   lat;
        logic seen;

        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_mf = '0; cfg_degree = '0;
        start = 1'b0; rule_count = '0;
        m_area = '0; m_wsum = '0; m_drop_deg = '0;

        vecs[0] = '{n: 4'd3, degs: {160'd0, 32'h800, 32'h0, Q12_ONE},
                    area: 32'h1000, wsum: 32'h1000, drop_deg: 32'h0, exp_used: 4'd2,
                    exp_area: 48'h2000, exp_wsum: 48'h2000, exp_to: 1'b0,
                    exp_last_deg: 32'h800, exp_last_idx: 3'd2, exp_lat: 0};
        vecs[1] = '{n: 4'd0, degs: ALLPOS, area: 32'h1000, wsum: 32'h1000, drop_deg: 32'h0,
                    exp_used: 4'd0, exp_area: 48'h0, exp_wsum: 48'h0, exp_to: 1'b0,
                    exp_last_deg: 32'h0, exp_last_idx: 3'd0, exp_lat: 3};
        vecs[2] = '{n: 4'd1, degs: ALLPOS, area: 32'hFFFF_FFF0, wsum: 32'h20, drop_deg: 32'h0,
                    exp_used: 4'd1, exp_area: 48'hFFFF_FFFF_FFF0, exp_wsum: 48'h20,
                    exp_to: 1'b0, exp_last_deg: 32'h1000, exp_last_idx: 3'd0, exp_lat: 0};
        vecs[3] = '{n: 4'd8, degs: ALLPOS, area: 32'h100, wsum: 32'hFFFF_FF00, drop_deg: 32'h0,
                    exp_used: 4'd8, exp_area: 48'h800, exp_wsum: 48'hFFFF_FFFF_F800,
                    exp_to: 1'b0, exp_last_deg: 32'h1007, exp_last_idx: 3'd7, exp_lat: 0};
        vecs[4] = '{n: 4'd8, degs: ALLPOS, area: 32'h7FFF_FFFF, wsum: 32'h1,
                    drop_deg: 32'h1003, exp_used: 4'd8, exp_area: 48'h3_7FFF_FFF9,
                    exp_wsum: 48'h7, exp_to: 1'b1, exp_last_deg: 32'h1007,
                    exp_last_idx: 3'd7, exp_lat: 75};
        vecs[5] = '{n: 4'd5,
                    degs: {96'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h0, 32'hFFFF_F000},
                    area: 32'h8000_0000, wsum: 32'h1, drop_deg: 32'h0, exp_used: 4'd2,
                    exp_area: 48'hFFFF_0000_0000, exp_wsum: 48'h2, exp_to: 1'b0,
                    exp_last_deg: 32'h7FFF_FFFF, exp_last_idx: 3'd4, exp_lat: 0};
        vecs[6] = '{n: 4'd4, degs: {128'd0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
                    area: 32'h55, wsum: 32'h66, drop_deg: 32'h0, exp_used: 4'd0,
                    exp_area: 48'h0, exp_wsum: 48'h0, exp_to: 1'b0, exp_last_deg: 32'h0,
                    exp_last_idx: 3'd0, exp_lat: 7};

        #1;
        chk("rst_cw_rst_low", cw_rst, 1'b0);
        chk("rst_flags", {busy, result_valid, cw_input_valid, timeout_err}, 4'b0);
        chk("rst_sums", {total_area, total_weighted, rules_used}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("cw_rst_first_edge", cw_rst, 1'b1);
        chk("idle_not_busy", busy, 1'b0);

        for (int v = 0; v < 7; v++) begin
            load_table(vecs[v].degs);
            m_area     = vecs[v].area;
            m_wsum     = vecs[v].wsum;
            m_drop_deg = vecs[v].drop_deg;
            do_batch(vecs[v].n, lat);
            chk($sformatf("v%0d_timeout_err", v), timeout_err, vecs[v].exp_to);
            chk($sformatf("v%0d_rules_used", v), rules_used, vecs[v].exp_used);
            chk($sformatf("v%0d_total_area", v), total_area, vecs[v].exp_area);
            chk($sformatf("v%0d_total_weighted", v), total_weighted, vecs[v].exp_wsum);
            if (vecs[v].exp_lat != 0) begin
                chk($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
            end
            if (vecs[v].exp_used != 4'd0) begin
                chk($sformatf("v%0d_last_degree", v), cw_consequent_degree,
                    vecs[v].exp_last_deg);
                chk($sformatf("v%0d_last_mf", v), cw_outMF_data,
                    mf_of(int'(vecs[v].exp_last_idx)));
            end
            @(negedge clk);
            chk($sformatf("v%0d_rv_one_cycle", v), {result_valid, busy}, 2'b00);
            chk($sformatf("v%0d_area_held", v), total_area, vecs[v].exp_area);
        end

        // cfg write and second start while busy must both be dropped
        load_table(ALLPOS);
        m_area = 32'h10; m_wsum = 32'h10; m_drop_deg = 32'h0;
        @(negedge clk);
        start = 1'b1; rule_count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_degree = 32'h5555; cfg_mf = '1;
        start = 1'b1; rule_count = 4'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        lat = 0;
        while (!result_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_batch_done", result_valid, 1'b1);
        chk("busy_batch_rules_used", rules_used, 4'd8);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("busy_start_ignored", seen, 1'b0);
        do_batch(4'd1, lat);
        chk("busy_write_dropped_deg", cw_consequent_degree, 32'h1000);
        chk("busy_write_dropped_mf", cw_outMF_data, mf_of(0));

        // oversize rule_count is ignored and leaves the previous results alone
        @(negedge clk);
        start = 1'b1; rule_count = 4'd9;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen |= busy | ~cw_rst;
            @(negedge clk);
        end
        chk("count9_ignored", seen, 1'b0);
        chk("count9_holds_rules_used", rules_used, 4'd1);

        // reset while draining a batch that is missing a result
        load_table(ALLPOS);
        m_area = 32'h100; m_wsum = 32'h100; m_drop_deg = 32'h1003;
        @(negedge clk);
        start = 1'b1; rule_count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("drain_still_busy", {busy, result_valid}, 2'b10);
        #2 rst = 1'b0;
        #1;
        chk("midrst_cw_rst_low", cw_rst, 1'b0);
        chk("midrst_flags", {busy, result_valid, cw_input_valid, timeout_err}, 4'b0);
        chk("midrst_sums", {total_area, total_weighted, rules_used}, '0);
        chk("midrst_issue_data", {cw_consequent_degree, cw_outMF_data}, '0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= result_valid;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        seen |= result_valid;
        chk("midrst_no_result_valid", seen, 1'b0);
        chk("midrst_cw_rst_release", cw_rst, 1'b1);
        m_drop_deg = 32'h0;
        do_batch(4'd8, lat);
        chk("table_cleared_rules_used", rules_used, 4'd0);
        chk("table_cleared_sums", {total_area, total_weighted}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
